mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk (rising edge) and rst (0 = reset, sampled only on clk rising edge).
REQ-002 The block SHALL provide these ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- start  in  1  CPU request strobe, sampled in IDLE only
- Aaddr  in  16  data-port word address
- Baddr  in  16  instruction-port word address
- dataWrtie  in  16  store data
- ExMemControl  in  2  00 none, 01 load, 10 store, 11 treated as none
- AmemRead  out  16  registered load result
- BmemRead  out  16  registered instruction word
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- ram_addr  out  16  SRAM address
- ram_wdata  out  16  SRAM write data
- ram_wdata_en  out  1  tristate enable for ram_wdata
- ram_rdata  in  16  SRAM read data
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active low

Function
REQ-003 The block SHALL implement states IDLE, DATA_RD, WR_SETUP, WR_PULSE, WR_HOLD, INST_RD, DONE.
REQ-004 In IDLE with start=1 at an edge, the block SHALL latch Aaddr, Baddr, dataWrtie and ExMemControl, and SHALL go to DATA_RD (01), WR_SETUP (10) or INST_RD (00/11).
REQ-005 In IDLE with start=0, or in any non-IDLE state, start SHALL be ignored; latched values SHALL not change until the next accepted start.
REQ-006 Transitions: DATA_RD->INST_RD; WR_SETUP->WR_PULSE->WR_HOLD->INST_RD; INST_RD->DONE; DONE->IDLE. Each state SHALL last exactly one cycle.
REQ-007 Latency from the accepting edge to the cycle with done=1 SHALL be 2 cycles for none, 3 for load and 5 for store; done SHALL be high only in DONE.
REQ-008 In DATA_RD and INST_RD: ram_addr = latched Aaddr or Baddr respectively, ram_ce_n=0, ram_oe_n=0, ram_we_n=1.
REQ-009 At the edge leaving DATA_RD, AmemRead SHALL capture ram_rdata; at the edge leaving INST_RD, BmemRead SHALL capture ram_rdata. Both SHALL otherwise hold their values.
REQ-010 In WR_SETUP, WR_PULSE and WR_HOLD: ram_addr = latched Aaddr, ram_wdata = latched dataWrtie, ram_wdata_en=1, ram_ce_n=0, ram_oe_n=1. ram_we_n SHALL be 0 only in WR_PULSE.
REQ-011 ram_oe_n and ram_we_n SHALL never both be 0 in the same cycle; ram_wdata_en SHALL be 0 whenever ram_oe_n=0.
REQ-012 In IDLE and DONE: ram_ce_n=1, ram_oe_n=1, ram_we_n=1, ram_wdata_en=0, and ram_addr SHALL hold its last value.
REQ-013 A store SHALL leave AmemRead unchanged. A store to the address that the same request then fetches SHALL return the new data in BmemRead.
REQ-014 Addresses SHALL pass through unmodified over the full range 0x0000-0xFFFF, with no wrap or offset arithmetic.

Reset
REQ-015 When rst=0 at an edge, the block SHALL enter IDLE, which holds ram_we_n=1 from that edge onward, including mid-store.
REQ-016 The same reset edge SHALL clear AmemRead, BmemRead, ram_addr, ram_wdata and the latched request to 0x0000, and SHALL set busy=0 and done=0.
REQ-017 A start asserted while rst=0 SHALL be ignored.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Fetch only: ExMemControl=00, Baddr=0x0010, SRAM[0x0010]=0x1234, start pulse -> BmemRead=0x1234; done high exactly 2 cycles after start; AmemRead unchanged.
- Load: ExMemControl=01, Aaddr=0x8000, SRAM[0x8000]=0xBEEF, Baddr=0x0011 -> AmemRead=0xBEEF, then BmemRead=SRAM[0x0011]; done at +3; ram_we_n stays 1 throughout.
- Store then fetch of the same address: ExMemControl=10, Aaddr=Baddr=0x0020, dataWrtie=0xA5A5 -> ram_we_n low for exactly one cycle, with addr and data stable one cycle before and one cycle after; BmemRead=0xA5A5; done at +5.
- Start during busy: second start pulse 1 cycle after an accepted start, with different addresses -> ignored; only the first request is serviced; exactly one done pulse.
- Reset mid-store: rst=0 during WR_PULSE -> ram_we_n=1 and busy=0 after that edge; AmemRead=BmemRead=0x0000; a following fetch completes normally.
- Boundary: ExMemControl=11, Baddr=0xFFFF -> behaves as fetch only; ram_addr=0xFFFF; no write strobe.

Source files
------------

// File: rtl/mem_responder_if.sv
// Bundles the CPU request/response signals and the asynchronous SRAM bus of mem_responder.
// slave is the responder's view; master is the CPU/SRAM side (used by the bench).
interface mem_responder_if;
    logic        start;
    logic [15:0] Aaddr;
    logic [15:0] Baddr;
    logic [15:0] dataWrtie;
    logic [1:0]  ExMemControl;
    logic [15:0] AmemRead;
    logic [15:0] BmemRead;
    logic        busy;
    logic        done;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_wdata_en;
    logic [15:0] ram_rdata;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;

    modport slave (
        input  start, Aaddr, Baddr, dataWrtie, ExMemControl, ram_rdata,
        output AmemRead, BmemRead, busy, done,
               ram_addr, ram_wdata, ram_wdata_en, ram_ce_n, ram_oe_n, ram_we_n
    );

    modport master (
        output start, Aaddr, Baddr, dataWrtie, ExMemControl, ram_rdata,
        input  AmemRead, BmemRead, busy, done,
               ram_addr, ram_wdata, ram_wdata_en, ram_ce_n, ram_oe_n, ram_we_n
    );
endinterface

// File: rtl/mem_responder.sv
// Serialises one optional data access (load/store) plus one instruction fetch per CPU request
// onto a single asynchronous SRAM, with a three-phase write so address/data bracket the strobe.
module mem_responder (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave memBus
);
    typedef enum logic [2:0] {
        IDLE, DATA_RD, WR_SETUP, WR_PULSE, WR_HOLD, INST_RD, DONE
    } stateT;

    stateT       state, nextState;
    logic [15:0] aAddrQ, bAddrQ, wDataQ, lastAddrQ;
    logic [15:0] aReadQ, bReadQ;
    logic [15:0] ramAddr;
    logic        ceN, oeN, weN, wdataEn;
    logic        accept;

    assign accept = (state == IDLE) && memBus.start;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // IDLE/DONE fall back to lastAddrQ so the SRAM address bus holds its last value.
    always_comb begin
        nextState = state;
        ceN       = 1'b1;
        oeN       = 1'b1;
        weN       = 1'b1;
        wdataEn   = 1'b0;
        ramAddr   = lastAddrQ;
        case (state)
            IDLE: begin
                if (memBus.start) begin
                    case (memBus.ExMemControl)
                        2'b01:   nextState = DATA_RD;
                        2'b10:   nextState = WR_SETUP;
                        default: nextState = INST_RD;
                    endcase
                end
            end
            DATA_RD: begin
                ceN       = 1'b0;
                oeN       = 1'b0;
                ramAddr   = aAddrQ;
                nextState = INST_RD;
            end
            WR_SETUP: begin
                ceN       = 1'b0;
                wdataEn   = 1'b1;
                ramAddr   = aAddrQ;
                nextState = WR_PULSE;
            end
            WR_PULSE: begin
                ceN       = 1'b0;
                weN       = 1'b0;
                wdataEn   = 1'b1;
                ramAddr   = aAddrQ;
                nextState = WR_HOLD;
            end
            WR_HOLD: begin
                ceN       = 1'b0;
                wdataEn   = 1'b1;
                ramAddr   = aAddrQ;
                nextState = INST_RD;
            end
            INST_RD: begin
                ceN       = 1'b0;
                oeN       = 1'b0;
                ramAddr   = bAddrQ;
                nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            aAddrQ    <= '0;
            bAddrQ    <= '0;
            wDataQ    <= '0;
            lastAddrQ <= '0;
            aReadQ    <= '0;
            bReadQ    <= '0;
        end else begin
            lastAddrQ <= ramAddr;
            if (accept) begin
                aAddrQ <= memBus.Aaddr;
                bAddrQ <= memBus.Baddr;
                wDataQ <= memBus.dataWrtie;
            end
            if (state == DATA_RD) aReadQ <= memBus.ram_rdata;
            if (state == INST_RD) bReadQ <= memBus.ram_rdata;
        end
    end

    assign memBus.AmemRead     = aReadQ;
    assign memBus.BmemRead     = bReadQ;
    assign memBus.busy         = (state != IDLE);
    assign memBus.done         = (state == DONE);
    assign memBus.ram_addr     = ramAddr;
    assign memBus.ram_wdata    = wDataQ;
    assign memBus.ram_wdata_en = wdataEn;
    assign memBus.ram_ce_n     = ceN;
    assign memBus.ram_oe_n     = oeN;
    assign memBus.ram_we_n     = weN;
endmodule
